// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the MEM stage and data_mem_ctrl.
// The master holds the request until ready; the slave returns result/ready/busy/err.
interface data_mem_ctrl_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  byte_en;
    logic [31:0] result;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output mem_read, mem_write, address, data, byte_en,
        input  result, ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, address, data, byte_en,
        output result, ready, busy, err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle big-endian data memory; ready pulses WAIT_CYCLES+1 cycles after the request is first seen.
// Requester holds the request until ready; DMEM_RANGE_CHECK_EN adds the out-of-range err flag.
module data_mem_ctrl #(
    parameter int BASE_ADDR   = 1024,
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    data_mem_ctrl_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] BASE     = 32'(BASE_ADDR);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;

    logic          r_wr;
    logic          r_rd;
    logic [31:0]   r_addr;
    logic [31:0]   r_data;
    logic [3:0]    r_be;
    logic [31:0]   r_result;
    logic          r_oor;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_in_idle;
    logic          w_accept;
    logic          w_commit;
    logic          w_eff_wr;
    logic          w_eff_rd;
    logic [31:0]   w_eff_addr;
    logic [31:0]   w_eff_data;
    logic [3:0]    w_eff_be;
    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_oor;

    // With zero wait states the commit edge is also the accept edge, so the
    // live inputs are used in IDLE and the latched copy everywhere else.
    assign w_in_idle  = (r_state == S_IDLE);
    assign w_accept   = w_in_idle & (bus.mem_read | bus.mem_write);
    assign w_eff_wr   = w_in_idle ? bus.mem_write : r_wr;
    assign w_eff_rd   = w_in_idle ? (bus.mem_read & ~bus.mem_write) : r_rd;
    assign w_eff_addr = w_in_idle ? bus.address : r_addr;
    assign w_eff_data = w_in_idle ? bus.data    : r_data;
    assign w_eff_be   = w_in_idle ? bus.byte_en : r_be;

    assign w_off = w_eff_addr - BASE;
    assign w_idx = AW'(w_off >> 2);

`ifdef DMEM_RANGE_CHECK_EN
    assign w_oor = (w_eff_addr < BASE) || (w_off >= 32'(4 * DEPTH_WORDS));
`else
    assign w_oor = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.mem_read | bus.mem_write) begin
                    w_cnt_nxt   = CNT_INIT;
                    w_state_nxt = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_commit = (w_state_nxt == S_DONE) && (r_state != S_DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_addr   <= 32'd0;
            r_data   <= 32'd0;
            r_be     <= 4'd0;
            r_result <= 32'd0;
            r_oor    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_wr   <= bus.mem_write;
                r_rd   <= bus.mem_read & ~bus.mem_write;
                r_addr <= bus.address;
                r_data <= bus.data;
                r_be   <= bus.byte_en;
            end
            if (w_commit) begin
                r_oor <= w_oor;
                if (w_eff_rd) begin
                    r_result <= w_oor ? 32'd0 : r_mem[w_idx];
                end
            end
        end
    end

    // Array contents survive reset; lane l holds data[8*l+7:8*l] (lane 3 = lowest byte address).
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_commit && w_eff_wr && !w_oor) begin
            for (int l = 0; l < 4; l++) begin
                if (w_eff_be[l]) begin
                    r_mem[w_idx][8*l +: 8] <= w_eff_data[8*l +: 8];
                end
            end
        end
    end

    assign bus.result = r_result;
    assign bus.ready  = (r_state == S_DONE);
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.err    = (r_state == S_DONE) & r_oor;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: DUT 0 uses WAIT_CYCLES=2, DUT 1 uses WAIT_CYCLES=0; a per-access
// timing/content model is checked every cycle, plus literal result checks.
module tb_data_mem_ctrl;
    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst = 2'b11;
    logic        t_rd [2];
    logic        t_wr [2];
    logic [31:0] t_addr [2];
    logic [31:0] t_dat [2];
    logic [3:0]  t_be [2];

    data_mem_ctrl_if bus0 ();
    data_mem_ctrl_if bus1 ();

    assign bus0.mem_read  = t_rd[0];
    assign bus0.mem_write = t_wr[0];
    assign bus0.address   = t_addr[0];
    assign bus0.data      = t_dat[0];
    assign bus0.byte_en   = t_be[0];
    assign bus1.mem_read  = t_rd[1];
    assign bus1.mem_write = t_wr[1];
    assign bus1.address   = t_addr[1];
    assign bus1.data      = t_dat[1];
    assign bus1.byte_en   = t_be[1];

    data_mem_ctrl #(.BASE_ADDR(1024), .DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut0 (
        .i_clk(clk), .i_rst(rst[0]), .bus(bus0)
    );
    data_mem_ctrl #(.BASE_ADDR(1024), .DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut1 (
        .i_clk(clk), .i_rst(rst[1]), .bus(bus1)
    );

    logic [31:0] o_res [2];
    logic        o_rdy [2];
    logic        o_busy [2];
    logic        o_err [2];
    assign o_res[0]  = bus0.result;
    assign o_rdy[0]  = bus0.ready;
    assign o_busy[0] = bus0.busy;
    assign o_err[0]  = bus0.err;
    assign o_res[1]  = bus1.result;
    assign o_rdy[1]  = bus1.ready;
    assign o_busy[1] = bus1.busy;
    assign o_err[1]  = bus1.err;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] rst_hit = 2'b00;
    always @(posedge clk) rst_hit <= rst;

    // Access record written by the stimulus; expectations derived from it.
    int          acc_start [2] = '{-10, -10};
    int          acc_end [2]   = '{-10, -10};
    bit          acc_rd [2]    = '{1'b0, 1'b0};
    bit          acc_oor [2]   = '{1'b0, 1'b0};
    logic [31:0] acc_rdata [2] = '{32'd0, 32'd0};
    logic [31:0] mm [2][64];

    bit          chk_en = 1'b0;
    int          lit_seq = 0;
    int          lit_done = 0;
    int          lit_dut = 0;
    string       lit_name = "";
    logic [31:0] lit_exp = 32'd0;

    int          n_vec = 0;
    int          n_bad = 0;
    bit          killed [2] = '{1'b1, 1'b1};
    logic [31:0] m_res [2] = '{32'd0, 32'd0};

    always @(negedge clk) begin
        bit exp_rdy;
        bit exp_busy;
        bit exp_err;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                if (cyc == acc_start[d]) killed[d] = 1'b0;
                if (rst_hit[d]) begin
                    killed[d] = 1'b1;
                    m_res[d]  = 32'd0;
                end
                exp_rdy  = !killed[d] && (cyc == acc_end[d]);
                exp_busy = !killed[d] && (cyc > acc_start[d]) && (cyc <= acc_end[d]);
                exp_err  = exp_rdy && acc_oor[d];
                if (exp_rdy && acc_rd[d]) m_res[d] = acc_rdata[d];
                n_vec++;
                if (o_rdy[d] !== exp_rdy) begin
                    n_bad++;
                    $display("FAIL ready d%0d cyc %0d: got %b want %b", d, cyc, o_rdy[d], exp_rdy);
                end
                n_vec++;
                if (o_busy[d] !== exp_busy) begin
                    n_bad++;
                    $display("FAIL busy d%0d cyc %0d: got %b want %b", d, cyc, o_busy[d], exp_busy);
                end
                n_vec++;
                if (o_err[d] !== exp_err) begin
                    n_bad++;
                    $display("FAIL err d%0d cyc %0d: got %b want %b", d, cyc, o_err[d], exp_err);
                end
                n_vec++;
                if (o_res[d] !== m_res[d]) begin
                    n_bad++;
                    $display("FAIL result d%0d cyc %0d: got %h want %h", d, cyc, o_res[d], m_res[d]);
                end
            end
            if (lit_seq != lit_done) begin
                lit_done = lit_seq;
                n_vec++;
                if (o_res[lit_dut] !== lit_exp) begin
                    n_bad++;
                    $display("FAIL %s d%0d: got %h want %h", lit_name, lit_dut, o_res[lit_dut], lit_exp);
                end
            end
        end
    end

    // Called #1 after a posedge (cycle c); returns #1 into the idle cycle after ready.
    task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] dat, input logic [3:0] be);
        int          w;
        bit          oor;
        int          idx;
        logic [31:0] off;
        w   = (d == 0) ? 2 : 0;
        off = a - BASE;
`ifdef DMEM_RANGE_CHECK_EN
        oor = (a < BASE) || (off >= 32'd256);
`else
        oor = 1'b0;
`endif
        idx = int'((off >> 2) % 32'd64);
        t_rd[d] = rd; t_wr[d] = wr; t_addr[d] = a; t_dat[d] = dat; t_be[d] = be;
        acc_start[d] = cyc;
        acc_end[d]   = cyc + w + 1;
        acc_oor[d]   = oor;
        acc_rd[d]    = rd && !wr;
        if (wr && !oor) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) mm[d][idx][8*l +: 8] = dat[8*l +: 8];
            end
        end
        acc_rdata[d] = oor ? 32'd0 : mm[d][idx];
        repeat (w + 1) @(posedge clk);
        #1;
        t_rd[d] = 1'b0; t_wr[d] = 1'b0; t_addr[d] = 32'd0; t_dat[d] = 32'd0; t_be[d] = 4'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int d, input logic [31:0] exp);
        lit_name = name;
        lit_dut  = d;
        lit_exp  = exp;
        lit_seq++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            t_rd[d] = 1'b0; t_wr[d] = 1'b0; t_addr[d] = 32'd0; t_dat[d] = 32'd0; t_be[d] = 4'd0;
        end
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 2'b00;
        lit("reset_result", 0, 32'd0);

        access(0, 0, 1, 32'd1024, 32'hDEADBEEF, 4'hF);
        access(0, 1, 0, 32'd1024, 32'd0, 4'h0);
        lit("basic_rd", 0, 32'hDEADBEEF);

        access(0, 0, 1, 32'd1028, 32'h11223344, 4'hF);
        access(0, 0, 1, 32'd1028, 32'hAABBCCDD, 4'b0101);
        access(0, 1, 0, 32'd1028, 32'd0, 4'h0);
        lit("byte_en_rd", 0, 32'h11BB33DD);
        access(0, 1, 0, 32'd1030, 32'd0, 4'h0);
        lit("low_bits_rd", 0, 32'h11BB33DD);
        access(0, 0, 1, 32'd1040, 32'h12345678, 4'h0);
        access(0, 0, 1, 32'd1040, 32'hCAFEF00D, 4'hF);
        access(0, 0, 1, 32'd1040, 32'h99999999, 4'h0);
        access(0, 1, 0, 32'd1040, 32'd0, 4'h0);
        lit("be_zero_rd", 0, 32'hCAFEF00D);

        // Reset during the first wait state of a write.
        access(0, 0, 1, 32'd1036, 32'h0BAD0BAD, 4'hF);
        t_wr[0] = 1'b1; t_addr[0] = 32'd1036; t_dat[0] = 32'd7; t_be[0] = 4'hF;
        acc_start[0] = cyc; acc_end[0] = cyc + 3; acc_oor[0] = 1'b0; acc_rd[0] = 1'b0;
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        t_wr[0] = 1'b0; t_addr[0] = 32'd0; t_dat[0] = 32'd0; t_be[0] = 4'd0;
        lit("abort_result", 0, 32'd0);
        access(0, 1, 0, 32'd1036, 32'd0, 4'h0);
        lit("abort_rd", 0, 32'h0BAD0BAD);

`ifdef DMEM_RANGE_CHECK_EN
        access(0, 0, 1, 32'd1020, 32'h55, 4'hF);
        access(0, 1, 0, 32'd1024, 32'd0, 4'h0);
        lit("oor_wr_suppressed", 0, 32'hDEADBEEF);
        access(0, 1, 0, 32'd1280, 32'd0, 4'h0);
        lit("oor_rd_zero", 0, 32'd0);
`else
        access(0, 0, 1, 32'd1280, 32'h55, 4'hF);
        access(0, 1, 0, 32'd1024, 32'd0, 4'h0);
        lit("wrap_rd", 0, 32'h55);
`endif

        access(1, 1, 1, 32'd1032, 32'd5, 4'hF);
        access(1, 1, 0, 32'd1032, 32'd0, 4'h0);
        lit("w0_rd", 1, 32'd5);
        access(1, 0, 1, 32'd1024, 32'hA5A5A5A5, 4'b1000);
        access(1, 1, 0, 32'd1024, 32'd0, 4'h0);
        lit("w0_lane3", 1, {8'hA5, mm[1][0][23:0]});

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, multi-cycle data memory for the ARM pipeline's MEM stage. It replaces the zero-latency byte-array memory with configurable depth, base address, wait states and byte-enable writes. A one-cycle `ready` pulse ends every access, and an optional out-of-range error flag is available. The pipeline freeze logic stalls while `(mem_read | mem_write) & ~ready`.

## Interface
- `BASE_ADDR`, default 1024: first byte address mapped to the array.
- `DEPTH_WORDS`, default 64: number of 32-bit words; must be a power of two, minimum 4.
- `WAIT_CYCLES`, default 2: extra wait states per access, range 0..15.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  read request; hold until `ready`.
- `mem_write`  in  1  write request; hold until `ready`.
- `address`  in  32  byte address.
- `data`  in  32  write data.
- `byte_en`  in  4  write byte lanes; `[3]` = `data[31:24]`.
- `result`  out  32  registered read data.
- `ready`  out  1  one-cycle access-complete pulse.
- `busy`  out  1  high while an access is in flight.
- `err`  out  1  out-of-range flag, valid with `ready`.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE:**
  - If `mem_write` or `mem_read` is sampled high, latch op, `address`, `data` and `byte_en`.
  - If both are high, write wins and the read is ignored.
  - Next state is WAIT with `cnt = WAIT_CYCLES-1`, or DONE directly if `WAIT_CYCLES == 0`.
- **WAIT:** decrement `cnt`; go to DONE when `cnt == 0`. Input changes are ignored (latched copy used).
- **DONE:**
  - `ready = 1` for exactly one cycle, then IDLE unconditionally.
  - A request still high in the following IDLE cycle is a new access.
- **Address mapping:**
  - `off = address - BASE_ADDR` (32-bit, wraps).
  - `idx = off[log2(DEPTH_WORDS)+1:2]`; `off[1:0]` is ignored, so no misalign trap.
- **Byte order:** big-endian. Byte at `4*idx` = bits `[31:24]`, `+1` = `[23:16]`, `+2` = `[15:8]`, `+3` = `[7:0]`.
- **Write:** on the edge entering DONE, update only the lanes with `byte_en` set. `byte_en = 0` performs no update but still completes with `ready`.
- **Read:** on the edge entering DONE, load the full word into `result`. `result` holds until the next completed read; writes do not change it.
- `busy = (state != IDLE)`.

## Timing
- Request first high in cycle c. `ready` is high in cycle c+`WAIT_CYCLES`+1.
  - `WAIT_CYCLES = 0`: `ready` in c+1.
  - Default (2): `ready` in c+3.
- Back-to-back accesses: the next request can be accepted in the cycle after `ready`. Throughput is one access per `WAIT_CYCLES`+2 cycles.
- Read-after-write to the same word returns the new data; the write commits before the next access is accepted.
- **Reset**, on any edge with `rst = 1`:
  - state = IDLE, `cnt = 0`.
  - `result = 0`, `ready = 0`, `busy = 0`, `err = 0`.
  - Array contents are not cleared.
- Reset mid-access aborts the access: no write commits, no `ready` pulse, and `result` is cleared.
- `rst` has priority over everything else.

## Configuration
- Macro: `DMEM_RANGE_CHECK_EN`.
- **Defined:**
  - An access is out of range if `address < BASE_ADDR` or `off >= 4*DEPTH_WORDS`.
  - For an out-of-range access, `err = 1` in the DONE cycle (same cycle as `ready`).
  - An out-of-range write is suppressed; an out-of-range read loads `result = 0`.
  - Latency is unchanged.
- **Undefined:**
  - `err` is tied to 0.
  - `idx` wraps modulo `DEPTH_WORDS`, so every address hits the array, aliasing included.

## Test plan
- **Basic write/read** (defaults, `BASE_ADDR = 1024`, `WAIT_CYCLES = 2`):
  - Write `0xDEADBEEF` to 1024 with `byte_en = 4'hF`; `ready` 3 cycles after request.
  - Then read 1024: `result = 0xDEADBEEF` in the `ready` cycle; `busy` is high for 3 cycles per access.
- **Byte enables:**
  - Write `0x11223344` to 1028 with `byte_en = F`.
  - Then write `0xAABBCCDD` to 1028 with `byte_en = 4'b0101`.
  - Read 1028: `0x11BB33DD`. Read 1030: also `0x11BB33DD` (low address bits ignored).
- **Simultaneous request and `WAIT_CYCLES = 0`:**
  - `mem_read = mem_write = 1`, `address = 1032`, `data = 5`: write performed and `ready` in the next cycle.
  - A read of 1032 then returns 5 with 1-cycle latency.
- **Reset mid-access:**
  - Write 7 to 1036; assert `rst` in the first WAIT cycle.
  - Required: no `ready`, `busy = 0` after the reset edge, `result = 0`.
  - A subsequent read of 1036 does not return 7 (old contents).
- **Range check, `DMEM_RANGE_CHECK_EN` defined:**
  - Write `0x55` to 1020: `err = 1` with `ready`, array unchanged.
  - Read 1024 + 4\*64: `err = 1`, `result = 0`.
- **Range check, `DMEM_RANGE_CHECK_EN` undefined:**
  - Write `0x55` to 1024 + 4\*64: `err = 0`.
  - Read 1024: returns `0x55` (wrap).
